// File: rtl/warp_sched_pkg.sv
// Shared encodings for the warp scheduler and the blocks it talks to
// (fetcher, LSUs): core state codes, LSU state codes, fetcher FETCHED code.
package warp_sched_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/rr_warp_picker.sv
// Combinational round-robin picker: searches the warps after cur_idx
// (wrapping, cur_idx itself considered last) for the first one whose
// warp_done bit is clear.
// Ports:
//   warp_done  in   per-warp retired mask (1 = not schedulable)
//   cur_idx    in   index of the warp that just ran
//   found      out  a live warp exists
//   next_idx   out  index of that warp (cur_idx when none found)
module rr_warp_picker #(
  parameter int NUM_WARPS = 4,
  localparam int WARP_ID_BITS = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0]    warp_done,
  input  logic [WARP_ID_BITS-1:0] cur_idx,
  output logic                    found,
  output logic [WARP_ID_BITS-1:0] next_idx
);

  logic [WARP_ID_BITS-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest live warp wins;
  // offset NUM_WARPS truncates to cur_idx itself. NUM_WARPS is a power of
  // two, so the truncating add is the modulo wrap.
  always_comb begin
    found    = 1'b0;
    next_idx = cur_idx;
    cand     = cur_idx;
    for (int i = NUM_WARPS; i >= 1; i--) begin
      cand = cur_idx + WARP_ID_BITS'(i);
      if (!warp_done[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp core scheduler. Sequences one compute core through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, one instruction per warp turn,
// rotating round-robin over the launched warps and retiring each on RET.
// Optional build macro: WARP_DIVERGENCE_CHECK_EN adds a sticky 'diverged'
// output flagging UPDATEs where enabled threads disagree on next PC.
// Ports:
//   clk, reset                  clock, async active-high reset
//   start, warps_launched       kernel launch (IDLE only), warp count
//   decoded_mem_read_enable     decoded load (informational)
//   decoded_mem_write_enable    decoded store (informational)
//   decoded_ret                 decoded RET
//   fetcher_state               fetcher FSM state
//   lsu_state                   per-thread LSU state
//   thread_enable               active threads of the current warp
//   next_pc                     per-thread next PC
//   current_pc, active_warp     selected warp and its PC
//   core_state                  scheduler state code
//   done                        all launched warps retired
//   diverged                    (macro only) sticky divergence flag
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | waiting for fetcher to report FETCHED
// DECODE  | decoder cycle
// REQUEST | LSUs issue requests
// WAIT    | stall while any enabled LSU is requesting/waiting
// EXECUTE | ALU cycle
// UPDATE  | commit PC or retire warp, pick next warp
// DONE    | all warps retired, hold until reset
module warp_scheduler
  import warp_sched_pkg::*;
#(
  parameter int NUM_WARPS        = 4,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS          = 8,
  localparam int WARP_ID_BITS    = $clog2(NUM_WARPS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [WARP_ID_BITS:0]                     warps_launched,
  input  logic                                      decoded_mem_read_enable,
  input  logic                                      decoded_mem_write_enable,
  input  logic                                      decoded_ret,
  input  logic [2:0]                                fetcher_state,
  input  logic [THREADS_PER_WARP-1:0][1:0]          lsu_state,
  input  logic [THREADS_PER_WARP-1:0]               thread_enable,
  input  logic [THREADS_PER_WARP-1:0][PC_BITS-1:0]  next_pc,
  output logic [PC_BITS-1:0]                        current_pc,
  output logic [WARP_ID_BITS-1:0]                   active_warp,
  output logic [2:0]                                core_state,
  output logic                                      done
`ifdef WARP_DIVERGENCE_CHECK_EN
  ,
  output logic                                      diverged
`endif
);

  localparam int TID_BITS = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

  core_state_e             state;
  logic [PC_BITS-1:0]      warp_pc [NUM_WARPS];
  logic [NUM_WARPS-1:0]    warp_done;

  logic [TID_BITS-1:0]     lead;
  logic [PC_BITS-1:0]      upd_pc;
  logic                    lsu_wait;
  logic                    div_now;
  logic [WARP_ID_BITS:0]   n_eff;
  logic [NUM_WARPS-1:0]    launch_mask;
  logic [NUM_WARPS-1:0]    done_after;
  logic                    pick_found;
  logic [WARP_ID_BITS-1:0] pick_idx;
  logic                    unused_mem_flags;

  assign core_state       = state;
  assign unused_mem_flags = decoded_mem_read_enable ^ decoded_mem_write_enable;

  // Lead thread supplies the warp's next PC; with no thread enabled the
  // last lane is used.
  always_comb begin
    lead = TID_BITS'(THREADS_PER_WARP - 1);
    for (int i = THREADS_PER_WARP - 1; i >= 0; i--)
      if (thread_enable[i]) lead = TID_BITS'(i);
  end
  assign upd_pc = next_pc[lead];

  always_comb begin
    lsu_wait = 1'b0;
    div_now  = 1'b0;
    for (int i = 0; i < THREADS_PER_WARP; i++) begin
      if (thread_enable[i] && lsu_busy(lsu_state[i])) lsu_wait = 1'b1;
      if (thread_enable[i] && (next_pc[i] != upd_pc)) div_now = 1'b1;
    end
  end

  // Out-of-range launch counts (0 or above NUM_WARPS) run every warp.
  always_comb begin
    n_eff = warps_launched;
    if ((warps_launched == '0) || (warps_launched > (WARP_ID_BITS+1)'(NUM_WARPS)))
      n_eff = (WARP_ID_BITS+1)'(NUM_WARPS);
    for (int i = 0; i < NUM_WARPS; i++)
      launch_mask[i] = ((WARP_ID_BITS+1)'(i) >= n_eff);
  end

  assign done_after = warp_done |
                      (decoded_ret ? (NUM_WARPS'(1) << active_warp) : '0);

  rr_warp_picker #(.NUM_WARPS(NUM_WARPS)) u_picker (
    .warp_done (done_after),
    .cur_idx   (active_warp),
    .found     (pick_found),
    .next_idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CORE_IDLE;
      current_pc  <= '0;
      active_warp <= '0;
      done        <= 1'b0;
      warp_done   <= '1;
      for (int i = 0; i < NUM_WARPS; i++) warp_pc[i] <= '0;
`ifdef WARP_DIVERGENCE_CHECK_EN
      diverged    <= 1'b0;
`endif
    end else begin
      case (state)
        CORE_IDLE: if (start) begin
          warp_done   <= launch_mask;
          active_warp <= '0;
          current_pc  <= '0;
          for (int i = 0; i < NUM_WARPS; i++) warp_pc[i] <= '0;
          state       <= CORE_FETCH;
        end
        CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) state <= CORE_DECODE;
        CORE_DECODE:  state <= CORE_REQUEST;
        CORE_REQUEST: state <= CORE_WAIT;
        CORE_WAIT:    if (!lsu_wait) state <= CORE_EXECUTE;
        CORE_EXECUTE: state <= CORE_UPDATE;
        CORE_UPDATE: begin
          warp_done <= done_after;
          if (!decoded_ret) begin
            warp_pc[active_warp] <= upd_pc;
`ifdef WARP_DIVERGENCE_CHECK_EN
            if (div_now) diverged <= 1'b1;
`endif
          end
          if (pick_found) begin
            active_warp <= pick_idx;
            // Same warp again: its PC register is being written this cycle.
            current_pc  <= (pick_idx == active_warp) ? upd_pc : warp_pc[pick_idx];
            state       <= CORE_FETCH;
          end else begin
            done  <= 1'b1;
            state <= CORE_DONE;
          end
        end
        CORE_DONE: state <= CORE_DONE;
        default:   state <= CORE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
module tb_warp_scheduler;
  localparam int NW  = 4;
  localparam int TPW = 4;
  localparam int PCB = 8;

  logic clk = 1'b0;
  logic reset, start;
  logic [2:0] warps_launched;
  logic decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret;
  logic [2:0] fetcher_state;
  logic [TPW-1:0][1:0] lsu_state;
  logic [TPW-1:0] thread_enable;
  logic [TPW-1:0][PCB-1:0] next_pc;
  logic [PCB-1:0] current_pc;
  logic [1:0] active_warp;
  logic [2:0] core_state;
  logic done;
`ifdef WARP_DIVERGENCE_CHECK_EN
  logic diverged;
`endif

  warp_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .warps_launched(warps_launched),
    .decoded_mem_read_enable(decoded_mem_read_enable),
    .decoded_mem_write_enable(decoded_mem_write_enable),
    .decoded_ret(decoded_ret), .fetcher_state(fetcher_state),
    .lsu_state(lsu_state), .thread_enable(thread_enable), .next_pc(next_pc),
    .current_pc(current_pc), .active_warp(active_warp),
    .core_state(core_state), .done(done)
`ifdef WARP_DIVERGENCE_CHECK_EN
    , .diverged(diverged)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-warp PC and liveness, the warp whose turn it is.
  int m_pc[NW];
  bit m_live[NW];
  int m_act;
  bit m_done;
  bit m_div;
  int ret_at[NW];

  bit use_fixed = 0;
  int fix_fd, fix_w;
  logic [3:0] fix_te;
  logic [3:0][1:0] fix_busy, fix_idle;
  bit fix_npc_en = 0;
  logic [3:0][7:0] fix_npc;

  function automatic logic [1:0] rnd_busy();
    return $urandom_range(0, 1) ? 2'b01 : 2'b10;
  endfunction
  function automatic logic [1:0] rnd_idle();
    return $urandom_range(0, 1) ? 2'b00 : 2'b11;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    fetcher_state = 3'b000;
    lsu_state = '0;
    decoded_ret = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_div = 0;
  endtask

  task automatic start_kernel(input int n);
    int ne;
    start = 1'b1;
    warps_launched = n[2:0];
    @(negedge clk);
    start = 1'b0;
    ne = (n == 0 || n > NW) ? NW : n;
    for (int i = 0; i < NW; i++) begin
      m_pc[i] = 0;
      m_live[i] = (i < ne);
    end
    m_act = 0;
    m_done = 0;
    checks++;
    if (core_state !== 3'b001) begin
      errors++;
      $display("FAIL launch_state: got %b exp 001", core_state);
    end
  endtask

  task automatic run_instr();
    int a, fd, w, k, nx;
    bit ret, found;
    logic [3:0] te;
    logic [3:0][1:0] lb, li;
    logic [3:0][7:0] np;
    logic [7:0] tgt;
    a = m_act;
    checks++;
    if (core_state !== 3'b001 || active_warp !== a[1:0] || current_pc !== m_pc[a][7:0]) begin
      errors++;
      $display("FAIL turn_entry: got state=%b warp=%0d pc=%0d exp state=001 warp=%0d pc=%0d",
               core_state, active_warp, current_pc, a, m_pc[a]);
    end
    if (use_fixed) begin
      fd = fix_fd; w = fix_w; te = fix_te; lb = fix_busy; li = fix_idle;
    end else begin
      fd = $urandom_range(0, 2);
      te = 4'($urandom_range(0, 15));
      w = (te == 4'b0000) ? 0 : $urandom_range(0, 3);
    end
    k = TPW - 1;
    for (int i = TPW - 1; i >= 0; i--) if (te[i]) k = i;
    if (!use_fixed) begin
      for (int i = 0; i < TPW; i++) begin
        lb[i] = (te[i] && i == k && w > 0) ? rnd_busy() : 2'($urandom_range(0, 3));
        li[i] = te[i] ? rnd_idle() : 2'($urandom_range(0, 3));
      end
    end
    if (fix_npc_en) np = fix_npc;
    else begin
      tgt = 8'((m_pc[a] + 1) % 256);
      for (int i = 0; i < TPW; i++)
        np[i] = (i == k || $urandom_range(0, 1)) ? tgt : 8'($urandom_range(0, 255));
    end
    ret = (m_pc[a] == ret_at[a]);

    fetcher_state = (fd > 0) ? 3'b001 : 3'b010;
    for (int i = 1; i <= fd; i++) begin
      @(negedge clk);
      checks++;
      if (core_state !== 3'b001) begin
        errors++;
        $display("FAIL fetch_hold: got %b exp 001", core_state);
      end
      if (i == fd) fetcher_state = 3'b010;
    end
    @(negedge clk);
    checks++;
    if (core_state !== 3'b010) begin
      errors++;
      $display("FAIL decode: got %b exp 010", core_state);
    end
    fetcher_state = 3'b000;
    thread_enable = te;
    lsu_state = lb;
    next_pc = np;
    decoded_ret = ret;
    decoded_mem_read_enable = 1'($urandom_range(0, 1));
    decoded_mem_write_enable = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (core_state !== 3'b011) begin
      errors++;
      $display("FAIL request: got %b exp 011", core_state);
    end
    @(negedge clk);
    checks++;
    if (core_state !== 3'b100) begin
      errors++;
      $display("FAIL wait_enter: got %b exp 100", core_state);
    end
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      checks++;
      if (core_state !== 3'b100) begin
        errors++;
        $display("FAIL wait_hold: got %b exp 100 at stall cycle %0d", core_state, i + 1);
      end
    end
    lsu_state = li;
    @(negedge clk);
    checks++;
    if (core_state !== 3'b101) begin
      errors++;
      $display("FAIL execute: got %b exp 101", core_state);
    end
    @(negedge clk);
    checks++;
    if (core_state !== 3'b110) begin
      errors++;
      $display("FAIL update: got %b exp 110", core_state);
    end
    @(negedge clk);
    // Model the commit and the round-robin choice.
    if (ret) m_live[a] = 0;
    else begin
      for (int i = 0; i < TPW; i++) if (te[i] && np[i] != np[k]) m_div = 1;
      m_pc[a] = np[k];
    end
    found = 0;
    nx = a;
    for (int j = 1; j <= NW; j++)
      if (!found && m_live[(a + j) % NW]) begin
        found = 1;
        nx = (a + j) % NW;
      end
    if (found) m_act = nx;
    else m_done = 1;
    checks++;
    if (core_state !== (found ? 3'b001 : 3'b111) || done !== !found) begin
      errors++;
      $display("FAIL after_update: got state=%b done=%b exp state=%b done=%b",
               core_state, done, found ? 3'b001 : 3'b111, !found);
    end
`ifdef WARP_DIVERGENCE_CHECK_EN
    checks++;
    if (diverged !== m_div) begin
      errors++;
      $display("FAIL diverged_track: got %b exp %b", diverged, m_div);
    end
`endif
    decoded_ret = 1'b0;
  endtask

  task automatic run_kernel(input int n, input int max_instr);
    int cnt;
    start_kernel(n);
    cnt = 0;
    while (!m_done && cnt < max_instr) begin
      run_instr();
      cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    warps_launched = 3'd0;
    decoded_mem_read_enable = 1'b0;
    decoded_mem_write_enable = 1'b0;
    decoded_ret = 1'b0;
    fetcher_state = 3'b000;
    lsu_state = '0;
    thread_enable = '0;
    next_pc = '0;
    #1;
    checks++;
    if (core_state !== 3'b000 || current_pc !== 8'd0 || active_warp !== 2'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got state=%b pc=%0d warp=%0d done=%b exp 000/0/0/0",
               core_state, current_pc, active_warp, done);
    end
    @(negedge clk);
    reset = 1'b0;
    m_div = 0;
    @(negedge clk);
    checks++;
    if (core_state !== 3'b000) begin
      errors++;
      $display("FAIL idle_hold: got %b exp 000", core_state);
    end
  endtask

  task automatic test_single_warp();
    do_reset();
    use_fixed = 1; fix_fd = 0; fix_w = 0; fix_te = 4'b1111;
    fix_busy = '0; fix_idle = '0; fix_npc_en = 0;
    ret_at[0] = 3;
    run_kernel(1, 10);
    use_fixed = 0;
    checks++;
    if (m_pc[0] != 3 || done !== 1'b1 || core_state !== 3'b111) begin
      errors++;
      $display("FAIL single_warp_end: got state=%b done=%b exp 111/1", core_state, done);
    end
    start = 1'b1;
    warps_launched = 3'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (core_state !== 3'b111 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done: got state=%b done=%b exp 111/1", core_state, done);
    end
  endtask

  task automatic test_three_warps();
    do_reset();
    for (int i = 0; i < NW; i++) ret_at[i] = 4;
    run_kernel(3, 40);
  endtask

  task automatic test_ret_rotation();
    do_reset();
    ret_at[0] = 3; ret_at[1] = 0; ret_at[2] = 3; ret_at[3] = 0;
    run_kernel(3, 40);
  endtask

  task automatic test_wait();
    do_reset();
    ret_at[0] = 1;
    use_fixed = 1; fix_fd = 1; fix_npc_en = 0;
    fix_te = 4'b1111; fix_w = 4;
    fix_busy = '0; fix_busy[2] = 2'b10; fix_idle = '0;
    start_kernel(1);
    run_instr();
    fix_te = 4'b1011; fix_w = 0;
    fix_idle = '0; fix_idle[2] = 2'b10;
    run_instr();
    use_fixed = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < NW; i++) ret_at[i] = 100;
    run_kernel(4, 6);
    fetcher_state = 3'b010;
    @(negedge clk);
    fetcher_state = 3'b000;
    thread_enable = 4'b1111;
    lsu_state = '0;
    lsu_state[0] = 2'b01;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (core_state !== 3'b100) begin
      errors++;
      $display("FAIL pre_reset_wait: got %b exp 100", core_state);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (core_state !== 3'b000 || current_pc !== 8'd0 || active_warp !== 2'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state=%b pc=%0d warp=%0d done=%b exp 000/0/0/0",
               core_state, current_pc, active_warp, done);
    end
    @(negedge clk);
    reset = 1'b0;
    lsu_state = '0;
    m_div = 0;
    for (int i = 0; i < NW; i++) ret_at[i] = $urandom_range(1, 4);
    run_kernel(4, 60);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < NW; i++) ret_at[i] = $urandom_range(0, 5);
      run_kernel($urandom_range(0, 7), 80);
      checks++;
      if (done !== 1'b1 || core_state !== 3'b111) begin
        errors++;
        $display("FAIL random_kernel_end: got state=%b done=%b exp 111/1", core_state, done);
      end
    end
  endtask

`ifdef WARP_DIVERGENCE_CHECK_EN
  task automatic test_divergence();
    do_reset();
    ret_at[0] = 5;
    use_fixed = 1; fix_fd = 0; fix_w = 0;
    fix_busy = '0; fix_idle = '0;
    fix_npc_en = 1;
    fix_npc[0] = 8'd5; fix_npc[1] = 8'd5; fix_npc[2] = 8'd9; fix_npc[3] = 8'd5;
    fix_te = 4'b1011;
    run_kernel(1, 5);
    checks++;
    if (diverged !== 1'b0) begin
      errors++;
      $display("FAIL no_divergence_masked: got %b exp 0", diverged);
    end
    do_reset();
    fix_te = 4'b1111;
    run_kernel(1, 5);
    repeat (3) @(negedge clk);
    checks++;
    if (diverged !== 1'b1) begin
      errors++;
      $display("FAIL divergence_sticky: got %b exp 1", diverged);
    end
    use_fixed = 0;
    fix_npc_en = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_warp();
    test_three_warps();
    test_ret_rotation();
    test_wait();
    test_async_reset();
    test_random();
`ifdef WARP_DIVERGENCE_CHECK_EN
    test_divergence();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Successor to the single-block core scheduler: sequences one compute core through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for up to NUM_WARPS independent warps.
- Holds one PC per warp and picks warps round-robin, one instruction per turn.
- Retires each warp individually on RET; raises done once every launched warp has retired.
- Sits between the fetcher/decoder/LSUs and the per-thread PC units; the same current_pc, core_state and done contract is kept for the rest of the core.

Parameters:
- NUM_WARPS, 4, number of warp contexts (power of 2, at least 2).
- THREADS_PER_WARP, 4, threads executing in lockstep per warp.
- PC_BITS, 8, program counter width.
- WARP_ID_BITS, $clog2(NUM_WARPS), width of the warp index (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  kernel launch pulse; honoured only in IDLE
- warps_launched  in  WARP_ID_BITS+1  number of warps to run (1..NUM_WARPS); sampled with start
- decoded_mem_read_enable  in  1  decoded load
- decoded_mem_write_enable  in  1  decoded store
- decoded_ret  in  1  decoded RET
- fetcher_state  in  3  fetcher FSM state (010 = FETCHED)
- lsu_state  in  [THREADS_PER_WARP] x 2  per-thread LSU state (01 REQUESTING, 10 WAITING)
- thread_enable  in  THREADS_PER_WARP  threads active in the current warp
- next_pc  in  [THREADS_PER_WARP] x PC_BITS  per-thread next PC
- current_pc  out  PC_BITS  PC of the selected warp
- active_warp  out  WARP_ID_BITS  index of the selected warp
- core_state  out  3  IDLE=000 FETCH=001 DECODE=010 REQUEST=011 WAIT=100 EXECUTE=101 UPDATE=110 DONE=111
- done  out  1  all launched warps have retired

Behaviour:
- Reset (async, any state) forces:
  - core_state=IDLE, current_pc=0, active_warp=0, done=0;
  - all warp PCs=0; warp_done mask all-ones (no warps live).
- IDLE: on start, warp_done[i] = (i >= warps_launched), active_warp=0, current_pc=0, next state FETCH. A warps_launched value of 0 or above NUM_WARPS is clamped to NUM_WARPS.
- FETCH: stays until fetcher_state==010, then DECODE.
- DECODE and REQUEST: one cycle each.
- WAIT: stays while any lsu_state[i] equals 01 or 10 with thread_enable[i]=1; disabled threads are ignored. Otherwise EXECUTE.
- EXECUTE: one cycle, then UPDATE.
- UPDATE (single cycle):
  - If decoded_ret: set warp_done[active_warp]; the stored PC is unchanged.
  - Else: warp_pc[active_warp] <= next_pc[k], where k is the lowest-index enabled thread. If thread_enable is all-zero, k = THREADS_PER_WARP-1.
  - Next warp = first index after active_warp, wrapping modulo NUM_WARPS and including active_warp itself last, whose warp_done bit is clear after this cycle's update.
  - A warp found: active_warp <= it, current_pc <= its PC (the just-written value if it is the same warp), next state FETCH.
  - No warp found: done <= 1, next state DONE.
- DONE: holds; done stays 1 until reset. start is ignored outside IDLE.
- Latency: minimum instruction takes 6 cycles with a 1-cycle fetch (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
- PC arithmetic wraps modulo 2^PC_BITS; the scheduler performs none itself.
- decoded_mem_* are informational only: WAIT is governed by lsu_state alone.

Optional Feature:
- Macro: WARP_DIVERGENCE_CHECK_EN.
- When defined:
  - Adds output port diverged (1 bit, reset 0).
  - In UPDATE without RET, diverged is set if any two enabled threads present different next_pc.
  - Sticky until reset; scheduling is unaffected.
- When undefined: the port and logic are absent.

Decomposition:
- Package warp_sched_pkg: core_state encoding constants, LSU state constants (REQUESTING=01, WAITING=10), fetcher FETCHED=010, shared with fetcher/LSU.
- One sub-module, rr_warp_picker: combinational round-robin find-next over the warp_done mask and current index; returns found flag and index.

Test Plan:
- Single warp (warps_launched=1), 1-cycle fetch, next_pc=PC+1, RET at PC 3 -> current_pc sequence 0,1,2,3; done=1 and core_state=111 after the 4th UPDATE.
- warps_launched=3, no RETs -> active_warp cycles 0,1,2,0,...; each warp's PC advances only on its own turn; warp 3 is never selected.
- Warp 1 executes RET while warps 0 and 2 are live -> rotation continues 2,0,2,0; done only after both remaining warps also hit RET.
- WAIT with lsu_state[2]=10, thread_enable=1111 for 5 cycles -> core_state stays 100 for 5 cycles, then 101. Same stimulus with thread_enable[2]=0 -> leaves WAIT after 1 cycle.
- Assert reset mid-WAIT (asynchronous, between clock edges) -> outputs take reset values immediately; a new start relaunches from PC 0 for all warps.
- With WARP_DIVERGENCE_CHECK_EN: next_pc = {5,5,9,5}, all threads enabled -> diverged=1 after UPDATE and stays 1; same PCs with thread_enable=1011 -> diverged stays 0.
